// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the serial program loader.
// States, sync byte and the error codes reported on err.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CNT_LO,
        CNT_HI,
        DATA,
        CKSUM
    } loader_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_COUNT   = 2'b01;
    localparam logic [1:0] ERR_CKSUM   = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

endpackage

// File: rtl/prog_loader_idle_timer.sv
// Inter-byte watchdog: fires on the TIMEOUT_CYC-th consecutive quiet
// clock while enabled; a kick on that same clock wins.
module idle_timer #(
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic kick,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || !enable || kick)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + CW'(1);
    end

    assign expired = enable && !kick && (r_cnt == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: frames UART bytes into instruction words,
// writes them to IMEM and releases the CPU after a verified checksum.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int DEPTH       = 4096,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_run,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err
);

    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    loader_state_t     r_state, w_state_nx;
    logic [15:0]       r_count, w_count_nx;
    logic [23:0]       r_word, w_word_nx;
    logic [1:0]        r_bidx, w_bidx_nx;
    logic [15:0]       r_widx, w_widx_nx;
    logic [7:0]        r_cksum, w_cksum_nx;
    logic              r_we, w_we_nx;
    logic [ADDR_W-1:0] r_addr, w_addr_nx;
    logic [31:0]       r_wdata, w_wdata_nx;
    logic              r_run, w_run_nx;
    logic              r_done, w_done_nx;
    logic [1:0]        r_err, w_err_nx;

    logic              w_busy;
    logic              w_expired;
    logic [15:0]       w_cnt_full;
    logic              w_cnt_bad;

    assign w_busy     = (r_state != IDLE);
    assign w_cnt_full = {rx_data, r_count[7:0]};
    assign w_cnt_bad  = (w_cnt_full == 16'd0) ||
                        ({1'b0, w_cnt_full} > DEPTH_W);

    idle_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_idle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (w_busy),
        .kick   (rx_valid),
        .expired(w_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_count <= '0;
            r_word  <= '0;
            r_bidx  <= '0;
            r_widx  <= '0;
            r_cksum <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_run   <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= ERR_NONE;
        end else begin
            r_state <= w_state_nx;
            r_count <= w_count_nx;
            r_word  <= w_word_nx;
            r_bidx  <= w_bidx_nx;
            r_widx  <= w_widx_nx;
            r_cksum <= w_cksum_nx;
            r_we    <= w_we_nx;
            r_addr  <= w_addr_nx;
            r_wdata <= w_wdata_nx;
            r_run   <= w_run_nx;
            r_done  <= w_done_nx;
            r_err   <= w_err_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_count_nx = r_count;
        w_word_nx  = r_word;
        w_bidx_nx  = r_bidx;
        w_widx_nx  = r_widx;
        w_cksum_nx = r_cksum;
        w_we_nx    = 1'b0;
        w_addr_nx  = r_addr;
        w_wdata_nx = r_wdata;
        w_run_nx   = r_run;
        w_done_nx  = r_done;
        w_err_nx   = r_err;

        if (w_expired) begin
            w_state_nx = IDLE;
            w_err_nx   = ERR_TIMEOUT;
        end else if (rx_valid) begin
            unique case (r_state)
                IDLE: begin
                    if (rx_data == SYNC_BYTE) begin
                        w_state_nx = CNT_LO;
                        w_done_nx  = 1'b0;
                        w_err_nx   = ERR_NONE;
                        w_cksum_nx = '0;
                        w_widx_nx  = '0;
                        w_bidx_nx  = '0;
                        w_run_nx   = 1'b0;
                    end
                end
                CNT_LO: begin
                    w_count_nx[7:0] = rx_data;
                    w_state_nx      = CNT_HI;
                end
                CNT_HI: begin
                    w_count_nx = w_cnt_full;
                    if (w_cnt_bad) begin
                        w_err_nx   = ERR_COUNT;
                        w_state_nx = IDLE;
                    end else begin
                        w_state_nx = DATA;
                    end
                end
                DATA: begin
                    w_cksum_nx = r_cksum ^ rx_data;
                    w_bidx_nx  = r_bidx + 2'd1;
                    if (r_bidx == 2'd3) begin
                        w_we_nx    = 1'b1;
                        w_addr_nx  = r_widx[ADDR_W-1:0];
                        w_wdata_nx = {rx_data, r_word};
                        w_widx_nx  = r_widx + 16'd1;
                        if (r_widx == r_count - 16'd1)
                            w_state_nx = CKSUM;
                    end else begin
                        w_word_nx[{r_bidx, 3'b000} +: 8] = rx_data;
                    end
                end
                CKSUM: begin
                    // a failed check leaves loaded words in place
                    if (rx_data == r_cksum) begin
                        w_done_nx = 1'b1;
                        w_run_nx  = 1'b1;
                    end else begin
                        w_err_nx  = ERR_CKSUM;
                    end
                    w_state_nx = IDLE;
                end
                default: w_state_nx = IDLE;
            endcase
        end
    end

    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign cpu_run    = r_run;
    assign busy       = w_busy;
    assign done       = r_done;
    assign err        = r_err;

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Serial program loader: the writer side of the CPU's instruction memory.
- Consumes a byte stream from the board UART receiver and frames it into 32-bit instruction words.
- Writes the words into instruction RAM through a write port, starting at address 0.
- Holds the CPU in reset while loading; releases it only after a checksum-verified load.

Parameters:
ADDR_W, 12, instruction RAM word-address width
DEPTH, 4096, maximum words accepted per load
TIMEOUT_CYC, 1000000, maximum idle clocks between bytes inside a frame

Ports:
clk  in  1  system clock
rst_n  in  1  reset
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe; rx_data valid this cycle
imem_we  out  1  instruction RAM write enable (one-cycle pulse)
imem_addr  out  ADDR_W  instruction RAM word address
imem_wdata  out  32  instruction word to write
cpu_run  out  1  drives CPU rst_n; 1 = CPU released
busy  out  1  frame in progress (state != IDLE)
done  out  1  last frame loaded and verified
err  out  2  00 none, 01 bad count, 10 checksum mismatch, 11 timeout

Behaviour:
- Reset: rst_n, synchronous, active-low; clock clk.
- On reset, all outputs are 0, state is IDLE, and the word counter, byte index and checksum are cleared.
- Frame format: SYNC 0xA5, COUNT_LO, COUNT_HI, then COUNT words of 4 bytes each (little-endian), then CKSUM.
- CKSUM is the XOR of the data bytes only; sync and count bytes are excluded.
- States: IDLE -> CNT_LO -> CNT_HI -> DATA -> CKSUM -> IDLE. Transitions occur only on rx_valid, except timeout.
- IDLE:
  - Bytes other than 0xA5 are ignored.
  - On 0xA5: go to CNT_LO; clear done, err, checksum, word counter and byte index.
  - cpu_run drops to 0 on the same edge; reloading always halts the CPU.
- CNT_LO: latch the low count byte.
- CNT_HI: latch the high count byte, then check the count.
  - If count == 0 or count > DEPTH: err <= 01 and return to IDLE; nothing is written.
  - Otherwise go to DATA.
- DATA:
  - Byte i (0..3) goes to bits [8i+7:8i] of the word being assembled; each byte is XORed into the checksum.
  - The 4th byte's rx_valid edge registers imem_we=1, imem_addr=word index and imem_wdata=assembled word.
  - imem_we is visible for exactly the next cycle.
  - The word index increments after each word. After word COUNT-1, go to CKSUM.
  - imem_addr and imem_wdata hold their last values when imem_we=0.
- CKSUM:
  - If the byte equals the running checksum: done <= 1, cpu_run <= 1, visible the cycle after the byte.
  - Otherwise: err <= 10 and cpu_run stays 0.
  - Either way, return to IDLE.
  - Words already written are not rolled back.
- Timeout:
  - The idle counter clears on every rx_valid and counts only while state != IDLE.
  - After TIMEOUT_CYC consecutive clocks with no rx_valid: err <= 11, return to IDLE, cpu_run stays 0.
- Sticky flags: err and done hold until the next accepted 0xA5. done and a nonzero err are never both 1.
- Simultaneous events: an rx_valid arriving on the timeout-threshold cycle takes priority; it is consumed and the counter clears.
- Reset mid-load: abort immediately and return everything to reset values. Partially written RAM contents are left in place.
- No backpressure: the block accepts one byte per rx_valid, back-to-back every cycle if presented.

Decomposition:
- Package prog_loader_pkg holds:
  - the loader_state_t enum {IDLE, CNT_LO, CNT_HI, DATA, CKSUM};
  - SYNC_BYTE = 8'hA5;
  - error-code constants ERR_NONE, ERR_COUNT, ERR_CKSUM, ERR_TIMEOUT.
- One sub-module, idle_timer:
  - inputs: clk, rst_n, enable (busy), kick (rx_valid);
  - output: expired;
  - parameter: TIMEOUT_CYC.
- The main FSM, word assembly and checksum stay in prog_loader.

Test Plan:
- Single word: A5 01 00 13 00 00 00 13 -> one imem_we pulse with addr 0, data 0x00000013; then done=1, cpu_run=1, err=00, busy=0.
- Two words, bad checksum: A5 02 00 78 56 34 12 EF BE AD DE 2B.
  - Writes addr 0 = 0x12345678 and addr 1 = 0xDEADBEEF.
  - Correct checksum is 2A, so err=10, done=0, cpu_run=0.
  - Resend with 2A -> done=1.
- Bad counts: A5 00 00 -> err=01, no imem_we. A5 01 10 (4097) -> err=01, state IDLE.
- Timeout (TIMEOUT_CYC=16): A5 01 00 then silence -> err=11 after 16 idle clocks.
  - A byte on clock 16 instead -> no error.
- Noise and reload:
  - 00 FF 5A in IDLE -> no state change.
  - After a successful load, a new A5 -> cpu_run=0, done=0 on the next cycle.
- Reset mid-DATA: rst_n low for 1 cycle after 2 data bytes -> all outputs 0, state IDLE.
  - A new full frame then loads normally.
